// File: rtl/mux_arb_2to1.sv
// mux_arb_2to1: packet-aware round-robin arbiter for the router's 2:1 output mux.
// Locks one input port from HEAD through TAIL (wormhole), drives the mux's
// one-hot sel, and returns pop strobes to the input buffers gated by oready.
//
// Optional build macro: MUX_ARB_STAT_EN adds per-port completed-packet
// counters (pkt_cnt_0 / pkt_cnt_1, CNTW bits, wrapping).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no packet in flight; arbitrate between HEAD requests
// S_LOCK0 | port 0 owns the mux until its TAIL is transferred
// S_LOCK1 | port 1 owns the mux until its TAIL is transferred
module mux_arb_2to1 #(
  parameter int TYPEW = 2,
  parameter int SELW  = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             oready,
  output logic [SELW-1:0]  sel,
  output logic             grant_0,
  output logic             grant_1,
  output logic             olock,
  output logic             proto_err
`ifdef MUX_ARB_STAT_EN
  ,
  output logic [CNTW-1:0]  pkt_cnt_0,
  output logic [CNTW-1:0]  pkt_cnt_1
`endif
);

  localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_DATA = TYPEW'(2);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

  localparam logic [SELW-1:0] SEL_NONE = '0;
  localparam logic [SELW-1:0] SEL_P0   = SELW'(1);
  localparam logic [SELW-1:0] SEL_P1   = SELW'(2);

  // Elaboration-time guard: sel must hold both port bits, counters need a bit.
  if (SELW < 2 || CNTW < 1 || TYPEW < 2) begin : g_bad_cfg
    $error("mux_arb_2to1: SELW must be >= 2, CNTW >= 1, TYPEW >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;      // 0: port 0 wins a tie, 1: port 1 wins
  logic            hdone_q, hdone_d;  // the locking HEAD has been transferred
  logic [SELW-1:0] sel_q, sel_d;
  logic            olock_q, olock_d;

  logic req_0, req_1;
  logic stray_0, stray_1;
  logic xfer_0, xfer_1;
  logic gnt_0, gnt_1;
  logic perr;
  logic tail_0, tail_1;

  assign req_0   = ivalid_0 & (itype_0 == T_HEAD);
  assign req_1   = ivalid_1 & (itype_1 == T_HEAD);
  assign stray_0 = ivalid_0 & ((itype_0 == T_DATA) | (itype_0 == T_TAIL));
  assign stray_1 = ivalid_1 & ((itype_1 == T_DATA) | (itype_1 == T_TAIL));
  assign xfer_0  = ivalid_0 & oready & (itype_0 != T_NONE);
  assign xfer_1  = ivalid_1 & oready & (itype_1 != T_NONE);

  // Next-state, arbitration and combinational grant/error generation.
  // The HEAD that wins arbitration is still at the buffer head when the lock
  // starts, so it is transferred inside LOCKi; only a second HEAD in the
  // same lock is a protocol error.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hdone_d = hdone_q;
    sel_d   = sel_q;
    gnt_0   = 1'b0;
    gnt_1   = 1'b0;
    perr    = 1'b0;
    tail_0  = 1'b0;
    tail_1  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d = SEL_NONE;
        if (stray_0 || stray_1) begin
          perr = 1'b1;
        end
        if (req_0 && (!req_1 || !ptr_q)) begin
          state_d = S_LOCK0;
          sel_d   = SEL_P0;
          hdone_d = 1'b0;
        end else if (req_1) begin
          state_d = S_LOCK1;
          sel_d   = SEL_P1;
          hdone_d = 1'b0;
        end
      end

      S_LOCK0: begin
        if (xfer_0) begin
          gnt_0 = 1'b1;
          if (itype_0 == T_HEAD) begin
            perr    = hdone_q;
            hdone_d = 1'b1;
          end
          if (itype_0 == T_TAIL) begin
            tail_0  = 1'b1;
            state_d = S_IDLE;
            sel_d   = SEL_NONE;
            ptr_d   = 1'b1;
          end
        end
      end

      S_LOCK1: begin
        if (xfer_1) begin
          gnt_1 = 1'b1;
          if (itype_1 == T_HEAD) begin
            perr    = hdone_q;
            hdone_d = 1'b1;
          end
          if (itype_1 == T_TAIL) begin
            tail_1  = 1'b1;
            state_d = S_IDLE;
            sel_d   = SEL_NONE;
            ptr_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = SEL_NONE;
      end
    endcase

    // Nothing is popped or flagged while reset is asserted.
    if (!rst_) begin
      gnt_0  = 1'b0;
      gnt_1  = 1'b0;
      perr   = 1'b0;
      tail_0 = 1'b0;
      tail_1 = 1'b0;
    end

    olock_d = (state_d != S_IDLE);
  end

  // State, pointer, sel and lock registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      hdone_q <= 1'b0;
      sel_q   <= SEL_NONE;
      olock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hdone_q <= hdone_d;
      sel_q   <= sel_d;
      olock_q <= olock_d;
    end
  end

  assign sel       = sel_q;
  assign olock     = olock_q;
  assign grant_0   = gnt_0;
  assign grant_1   = gnt_1;
  assign proto_err = perr;

`ifdef MUX_ARB_STAT_EN
  logic [CNTW-1:0] cnt_0_q, cnt_0_d;
  logic [CNTW-1:0] cnt_1_q, cnt_1_d;

  // Completed-packet counters step on each transferred TAIL and wrap freely.
  always_comb begin
    cnt_0_d = cnt_0_q;
    cnt_1_d = cnt_1_q;
    if (tail_0) begin
      cnt_0_d = cnt_0_q + CNTW'(1);
    end
    if (tail_1) begin
      cnt_1_d = cnt_1_q + CNTW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  assign pkt_cnt_0 = cnt_0_q;
  assign pkt_cnt_1 = cnt_1_q;
`else
  logic unused_tail;
  assign unused_tail = tail_0 | tail_1;
`endif

endmodule

// File: tb/tb_mux_arb_2to1.sv
// tb_mux_arb_2to1: directed vectors with hand-computed expectations.
// The driver pushes one expected record per cycle; a monitor on the falling
// edge pops it and compares against the DUT outputs of that cycle.
module tb_mux_arb_2to1;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] H = 2'd1;
  localparam logic [1:0] D = 2'd2;
  localparam logic [1:0] T = 2'd3;

  logic       clk;
  logic       rst_;
  logic       ivalid_0, ivalid_1, oready;
  logic [1:0] itype_0, itype_1;
  logic [4:0] sel;
  logic       grant_0, grant_1, olock, proto_err;

`ifdef MUX_ARB_STAT_EN
  logic [1:0] pkt_cnt_0, pkt_cnt_1;

  mux_arb_2to1 #(.TYPEW(2), .SELW(5), .CNTW(2)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .oready(oready), .sel(sel),
    .grant_0(grant_0), .grant_1(grant_1),
    .olock(olock), .proto_err(proto_err),
    .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
  );
`else
  mux_arb_2to1 #(.TYPEW(2), .SELW(5)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .oready(oready), .sel(sel),
    .grant_0(grant_0), .grant_1(grant_1),
    .olock(olock), .proto_err(proto_err)
  );
`endif

  typedef struct {
    string      name;
    logic       g0;
    logic       g1;
    logic [4:0] sel;
    logic       lock;
    logic       perr;
    logic       chk_cnt;
    logic [1:0] cnt0;
    logic [1:0] cnt1;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic       chk_cnt_g = 1'b0;
  logic [1:0] cur_cnt0  = 2'd0;
  logic [1:0] cur_cnt1  = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if ({grant_0, grant_1, sel, olock, proto_err} !== {e.g0, e.g1, e.sel, e.lock, e.perr}) begin
        errors++;
        $display("FAIL %s: got g0=%b g1=%b sel=%b lock=%b perr=%b, want g0=%b g1=%b sel=%b lock=%b perr=%b",
                 e.name, grant_0, grant_1, sel, olock, proto_err, e.g0, e.g1, e.sel, e.lock, e.perr);
      end
`ifdef MUX_ARB_STAT_EN
      if (e.chk_cnt) begin
        checks++;
        if ({pkt_cnt_0, pkt_cnt_1} !== {e.cnt0, e.cnt1}) begin
          errors++;
          $display("FAIL %s_cnt: got cnt0=%0d cnt1=%0d, want cnt0=%0d cnt1=%0d",
                   e.name, pkt_cnt_0, pkt_cnt_1, e.cnt0, e.cnt1);
        end
      end
`endif
    end
  end

  task automatic step(input string nm, input logic r,
                      input logic v0, input logic [1:0] t0,
                      input logic v1, input logic [1:0] t1, input logic rdy,
                      input logic eg0, input logic eg1, input logic [4:0] esel,
                      input logic elock, input logic eperr);
    exp_t e;
    rst_     = r;
    ivalid_0 = v0;
    itype_0  = t0;
    ivalid_1 = v1;
    itype_1  = t1;
    oready   = rdy;
    e.name = nm; e.g0 = eg0; e.g1 = eg1; e.sel = esel; e.lock = elock; e.perr = eperr;
    e.chk_cnt = chk_cnt_g; e.cnt0 = cur_cnt0; e.cnt1 = cur_cnt1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Unlocked cycle: no grants, sel=0, olock=0.
  task automatic idle(input string nm, input logic v0, input logic [1:0] t0,
                      input logic v1, input logic [1:0] t1, input logic eperr);
    step(nm, 1'b1, v0, t0, v1, t1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, eperr);
  endtask

  // Full packet on locked port p with oready=1; the other port holds (ov,ot).
  task automatic pkt(input string nm, input int p, input int n,
                     input logic ov, input logic [1:0] ot);
    logic [1:0] t;
    for (int k = 0; k < n; k++) begin
      t = (k == 0) ? H : ((k == n - 1) ? T : D);
      if (p == 0)
        step(nm, 1'b1, 1'b1, t, ov, ot, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0);
      else
        step(nm, 1'b1, ov, ot, 1'b1, t, 1'b1, 1'b0, 1'b1, 5'b00010, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [1:0] cnt_tbl [5];
    cnt_tbl = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst_ = 1'b0; ivalid_0 = 1'b0; ivalid_1 = 1'b0;
    itype_0 = N; itype_1 = N; oready = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    step("reset", 1'b0, 1'b0, N, 1'b0, N, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);

    // 1: port 1, 22-flit packet.
    idle("t1_head_idle", 1'b0, N, 1'b1, H, 1'b0);
    pkt("t1_pkt", 1, 22, 1'b0, N);
    idle("t1_after_tail", 1'b0, N, 1'b0, N, 1'b0);

    // 2: simultaneous HEADs, then saturated alternation 0,1,0,1.
    step("t2_reset", 1'b0, 1'b0, N, 1'b0, N, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    idle("t2_tie_a", 1'b1, H, 1'b1, H, 1'b0);
    pkt("t2_p0_a", 0, 3, 1'b1, H);
    idle("t2_tie_b", 1'b1, H, 1'b1, H, 1'b0);
    pkt("t2_p1_a", 1, 3, 1'b1, H);
    idle("t2_tie_c", 1'b1, H, 1'b1, H, 1'b0);
    pkt("t2_p0_b", 0, 3, 1'b1, H);
    idle("t2_tie_d", 1'b1, H, 1'b1, H, 1'b0);
    pkt("t2_p1_b", 1, 3, 1'b0, N);
    idle("t2_end", 1'b0, N, 1'b0, N, 1'b0);

    // 3: oready low for 3 cycles mid-packet on port 0.
    idle("t3_head_idle", 1'b1, H, 1'b0, N, 1'b0);
    step("t3_head", 1'b1, 1'b1, H, 1'b0, N, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0);
    step("t3_d0",   1'b1, 1'b1, D, 1'b0, N, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step("t3_stall", 1'b1, 1'b1, D, 1'b0, N, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0);
    step("t3_d1",   1'b1, 1'b1, D, 1'b0, N, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0);
    step("t3_tail", 1'b1, 1'b1, T, 1'b0, N, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0);
    idle("t3_end", 1'b0, N, 1'b0, N, 1'b0);

    // 4: protocol errors.
    idle("t4_idle_data0", 1'b1, D, 1'b0, N, 1'b1);
    idle("t4_idle_tail1", 1'b0, N, 1'b1, T, 1'b1);
    idle("t4_still_idle", 1'b0, N, 1'b0, N, 1'b0);
    idle("t4_head_idle", 1'b1, H, 1'b0, N, 1'b0);
    step("t4_head",     1'b1, 1'b1, H, 1'b0, N, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0);
    step("t4_dup_head", 1'b1, 1'b1, H, 1'b0, N, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b1);
    step("t4_data",     1'b1, 1'b1, D, 1'b0, N, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0);
    step("t4_tail",     1'b1, 1'b1, T, 1'b0, N, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0);
    idle("t4_end", 1'b0, N, 1'b0, N, 1'b0);

    // 5: reset in the middle of a port-1 packet.
    idle("t5_head_idle", 1'b0, N, 1'b1, H, 1'b0);
    step("t5_head", 1'b1, 1'b0, N, 1'b1, H, 1'b1, 1'b0, 1'b1, 5'b00010, 1'b1, 1'b0);
    step("t5_data", 1'b1, 1'b0, N, 1'b1, D, 1'b1, 1'b0, 1'b1, 5'b00010, 1'b1, 1'b0);
    step("t5_rst",  1'b0, 1'b0, N, 1'b1, D, 1'b1, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b0);
    idle("t5_after_rst", 1'b0, N, 1'b0, N, 1'b0);
    idle("t5_fresh_idle", 1'b0, N, 1'b1, H, 1'b0);
    pkt("t5_fresh", 1, 3, 1'b0, N);
    idle("t5_end", 1'b0, N, 1'b0, N, 1'b0);

`ifdef MUX_ARB_STAT_EN
    // 6: wrapping packet counters with CNTW=2.
    step("t6_reset", 1'b0, 1'b0, N, 1'b0, N, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    chk_cnt_g = 1'b1;
    cur_cnt0  = 2'd0;
    cur_cnt1  = 2'd0;
    for (int k = 0; k < 5; k++) begin
      idle("t6_idle", 1'b1, H, 1'b0, N, 1'b0);
      pkt("t6_pkt", 0, 2, 1'b0, N);
      cur_cnt0 = cnt_tbl[k];
    end
    idle("t6_end", 1'b0, N, 1'b0, N, 1'b0);
    chk_cnt_g = 1'b0;
`endif

    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending records, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
